instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Sequential program loader for the single-cycle MIPS core. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words using the opcode/funct encodings the core's decoder supports. It writes the words into instruction memory at consecutive word addresses through a 2-entry buffer that tolerates memory backpressure. It sits between the test/boot host and the instruction memory write port.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  opens a load session in IDLE; ignored elsewhere
- base_addr  in  ADDR_W  first write address, captured on start
- finish  in  1  closes the session (sampled in RUN only)
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_op  in  4  0 add, 1 addu, 2 addi, 3 addiu, 4 slt, 5 beq, 6 bne, 7 jr, 8 jal, 9 sw, 10 lw, 11-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- mem_we  out  1  write request (buffer non-empty)
- mem_addr  out  ADDR_W  write address of buffer head
- mem_data  out  32  encoded word at buffer head
- mem_ready  in  1  write completes when mem_we & mem_ready
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at session end
- word_count  out  ADDR_W+1  words accepted for writing this session
- bad_op  out  1  sticky; illegal in_op seen this session

## Operation
- Encoding:
  - R-type is {6'b0, rs, rt, rd, 5'b0, funct}; funct: add 100000, addu 100001, slt 101010, jr 001000.
  - jr forces rt = rd = 0.
  - I-type is {opcode, rs, rt, imm}; opcodes: addi 001000, addiu 001001, beq 000100, bne 000101, sw 101011, lw 100011.
  - jal is {000011, target}.
- States:
  - IDLE: start → RUN. Capture base_addr into the write pointer; clear word_count and bad_op.
  - RUN: accept bundles. finish → DRAIN; a bundle accepted in the same cycle is kept.
  - DRAIN: in_ready low. When the buffer is empty → IDLE, with done pulsed for that cycle.
- in_ready = (state == RUN) & (buffer count < 2) & (word_count < 2^ADDR_W).
  - No push when the buffer is full, even if a pop occurs in the same cycle.
- Legal op accepted:
  - encoded word and current write pointer are pushed into the buffer;
  - pointer increments modulo 2^ADDR_W (wraps to 0);
  - word_count increments.
- Illegal op accepted: consumed, nothing pushed, pointer/word_count unchanged, bad_op set.
- Buffer: 2-entry FIFO, strict order; pop on mem_we & mem_ready.
- Reset mid-session: buffer flushed immediately, pending writes dropped, state → IDLE.
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_data 0, busy 0, done 0, word_count 0, bad_op 0.

## Timing
- Bundle accepted at edge N → mem_we high in cycle N+1 with that word (buffer previously empty).
- Throughput: 1 word/cycle while mem_ready is held high.
- mem_addr and mem_data are stable while mem_we is high and mem_ready is low.
- With mem_ready low: 2 bundles accepted, then in_ready drops in the cycle after the second acceptance.
- done is asserted in the cycle after the last write completes; busy falls in that same cycle.
- start and finish asserted together in IDLE: only start acts.

## Test plan
- start, base_addr=0x010; addi rs=2 rt=7 imm=0x000F → next cycle mem_we=1, mem_addr=0x010, mem_data=0x2047000F; word_count=1.
- Back-to-back addu (rs=1, rt=2, rd=3), jr (rs=31), jal (target 0x40), sw (rs=29, rt=8, imm=4) with mem_ready=1:
  - data 0x00221821, 0x03E00008, 0x0C000040, 0xAFA80004
  - addresses 0x011-0x014, one per cycle.
- mem_ready low for 4 cycles while in_valid is held:
  - exactly 2 accepted, then in_ready=0;
  - on release, the words are written in order with no loss or duplication.
- in_op=12 accepted → bad_op=1, no mem_we, word_count unchanged; the next legal op is written at the unchanged address.
- ADDR_W=4, base_addr=14, three legal ops → writes at 14, 15, 0. After 16 accepted words, in_ready stays 0.
- finish with 2 words buffered and mem_ready low → busy=1 until both writes complete, then done=1 for one cycle and busy=0. Reset asserted mid-RUN with a full buffer → all outputs 0 immediately and no further writes.

Source files
------------

// File: rtl/instruction_encoder.sv
// MIPS program loader: packs decoded fields into 32-bit words and streams
// them into instruction memory at consecutive addresses via a 2-entry FIFO.
module instruction_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              bad_op
);

    localparam int WC_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [31:0]       data0, data1;

    logic        legal;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        unique case (in_op)
            4'd0:  word = {6'b0, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
            4'd1:  word = {6'b0, in_rs, in_rt, in_rd, 5'b0, 6'b100001};
            4'd2:  word = {6'b001000, in_rs, in_rt, in_imm};
            4'd3:  word = {6'b001001, in_rs, in_rt, in_imm};
            4'd4:  word = {6'b0, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
            4'd5:  word = {6'b000100, in_rs, in_rt, in_imm};
            4'd6:  word = {6'b000101, in_rs, in_rt, in_imm};
            4'd7:  word = {6'b0, in_rs, 5'b0, 5'b0, 5'b0, 6'b001000};
            4'd8:  word = {6'b000011, in_target};
            4'd9:  word = {6'b101011, in_rs, in_rt, in_imm};
            4'd10: word = {6'b100011, in_rs, in_rt, in_imm};
            default: legal = 1'b0;
        endcase
    end

    // word_count tops out at 2^ADDR_W: the whole memory has been written
    assign in_ready = (state == RUN) && (count != 2'd2) && !word_count[ADDR_W];
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign mem_we   = (count != 2'd0);
    assign pop      = mem_we && mem_ready;
    assign mem_addr = addr0;
    assign mem_data = data0;
    assign busy     = (state != IDLE);

    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            count      <= 2'd0;
            addr0      <= '0;
            addr1      <= '0;
            data0      <= 32'd0;
            data1      <= 32'd0;
            done       <= 1'b0;
            word_count <= '0;
            bad_op     <= 1'b0;
        end else begin
            done  <= 1'b0;
            count <= count_next;
            if (pop) begin
                addr0 <= addr1;
                data0 <= data1;
            end
            if (push) begin
                if (count == 2'd0 || pop) begin
                    addr0 <= wr_ptr;
                    data0 <= word;
                end else begin
                    addr1 <= wr_ptr;
                    data1 <= word;
                end
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                word_count <= word_count + WC_W'(1);
            end
            if (accept && !legal) begin
                bad_op <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        wr_ptr     <= base_addr;
                        word_count <= '0;
                        bad_op     <= 1'b0;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // leave as the last write retires so done lines up with it
                    if (count_next == 2'd0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: a 10-bit instance for the
// main flows and a 4-bit instance for address wrap and capacity limit.
module tb_instruction_encoder;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;

    logic        start_a = 0, finish_a = 0, valid_a = 0, mem_ready_a = 0;
    logic [9:0]  base_a = 10'd0;
    logic        in_ready_a, mem_we_a, busy_a, done_a, bad_op_a;
    logic [9:0]  mem_addr_a;
    logic [31:0] mem_data_a;
    logic [10:0] word_count_a;

    logic        start_b = 0, finish_b = 0, valid_b = 0, mem_ready_b = 0;
    logic [3:0]  base_b = 4'd0;
    logic        in_ready_b, mem_we_b, busy_b, done_b, bad_op_b;
    logic [3:0]  mem_addr_b;
    logic [31:0] mem_data_b;
    logic [4:0]  word_count_b;

    instruction_encoder #(.ADDR_W(10)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .finish(finish_a), .in_valid(valid_a), .in_ready(in_ready_a),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .mem_ready(mem_ready_a), .busy(busy_a), .done(done_a),
        .word_count(word_count_a), .bad_op(bad_op_a)
    );

    instruction_encoder #(.ADDR_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b),
        .finish(finish_b), .in_valid(valid_b), .in_ready(in_ready_b),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .mem_ready(mem_ready_b), .busy(busy_b), .done(done_b),
        .word_count(word_count_b), .bad_op(bad_op_b)
    );

    int checks = 0;
    int failures = 0;
    wr_t qa[$];
    wr_t qb[$];
    int exp_ptr_a = 0;
    int exp_ptr_b = 0;
    time last_wr_a = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: compare each completing write with the scoreboard head
    initial begin : mon_a
        logic       stall_prev;
        logic [9:0] pa;
        logic [31:0] pd;
        wr_t w;
        stall_prev = 1'b0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (mem_we_a) begin
                if (stall_prev)
                    chk("a_stall_hold", {mem_addr_a, mem_data_a}, {pa, pd});
                stall_prev = !mem_ready_a;
                pa = mem_addr_a;
                pd = mem_data_a;
            end else begin
                stall_prev = 1'b0;
            end
            if (mem_we_a && mem_ready_a) begin
                last_wr_a = $time;
                if (qa.size() == 0) begin
                    chk("a_unexpected_write", 64'(mem_addr_a), 64'hFFFF);
                end else begin
                    w = qa.pop_front();
                    chk("a_wr_addr", 64'(mem_addr_a), 64'(w.addr));
                    chk("a_wr_data", 64'(mem_data_a), 64'(w.data));
                end
            end
        end
    end

    initial begin : mon_b
        wr_t w;
        forever begin
            @(negedge clk);
            if (mem_we_b && mem_ready_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_write", 64'(mem_addr_b), 64'hFFFF);
                end else begin
                    w = qb.pop_front();
                    chk("b_wr_addr", 64'(mem_addr_b), 64'(w.addr));
                    chk("b_wr_data", 64'(mem_data_b), 64'(w.data));
                end
            end
        end
    end

    // Present one bundle from posedge+1 until accepted; returns at posedge+1
    task automatic send(input bit b, input logic [3:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] exp);
        bit ok;
        wr_t w;
        ok = 0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt;
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if ((b ? in_ready_b : in_ready_a) === 1'b1) begin
                ok = 1;
                if (op <= 4'd10) begin
                    w.data = exp;
                    if (b) begin
                        w.addr = 32'(exp_ptr_b & 15);
                        qb.push_back(w);
                        exp_ptr_b++;
                    end else begin
                        w.addr = 32'(exp_ptr_a & 1023);
                        qa.push_back(w);
                        exp_ptr_a++;
                    end
                end
            end
            step();
        end
        if (b) valid_b = 1'b0; else valid_a = 1'b0;
        if (!ok) chk("send_timeout", 64'(op), 64'hFFFF);
    endtask

    task automatic drain_wait_a();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && !mem_we_a) ok = 1;
        end
        if (!ok) chk("a_drain_timeout", 64'(qa.size()), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        time t0;
        bit  seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_a), 64'd0);
        chk("rst_mem_we", 64'(mem_we_a), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_a), 64'd0);
        chk("rst_mem_data", 64'(mem_data_a), 64'd0);
        chk("rst_flags", {busy_a, done_a, bad_op_a}, 64'd0);
        chk("rst_word_count", 64'(word_count_a), 64'd0);
        step();
        reset = 1'b0;
        step();

        // start with finish in IDLE: only start acts
        mem_ready_a = 1'b1;
        base_a = 10'h010;
        exp_ptr_a = 'h010;
        start_a = 1'b1;
        finish_a = 1'b1;
        step();
        start_a = 1'b0;
        finish_a = 1'b0;
        @(negedge clk);
        chk("start_busy", 64'(busy_a), 64'd1);
        chk("start_ready", 64'(in_ready_a), 64'd1);
        step();

        send(0, 4'd2, 5'd2, 5'd7, 5'd0, 16'h000F, 26'd0, 32'h2047000F);
        @(negedge clk);
        chk("first_we", 64'(mem_we_a), 64'd1);
        chk("first_addr", 64'(mem_addr_a), 64'h010);
        chk("first_data", 64'(mem_data_a), 64'h2047000F);
        chk("first_count", 64'(word_count_a), 64'd1);
        step();

        // back-to-back at full rate
        t0 = $time;
        send(0, 4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221821);
        send(0, 4'd7, 5'd31, 5'd5, 5'd6, 16'h1234, 26'd0, 32'h03E00008);
        send(0, 4'd8, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40, 32'h0C000040);
        send(0, 4'd9, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 32'hAFA80004);
        chk("b2b_cycles", 64'($time - t0), 64'd40);
        drain_wait_a();
        step();

        // backpressure
        mem_ready_a = 1'b0;
        send(0, 4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 32'h00853020);
        send(0, 4'd4, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 32'h00E8482A);
        @(negedge clk);
        chk("full_ready", 64'(in_ready_a), 64'd0);
        chk("full_head", 64'(mem_addr_a), 64'h015);
        step();
        fork
            send(0, 4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'd0, 32'h1022FFFE);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", 64'(in_ready_a), 64'd0);
                end
                step();
                mem_ready_a = 1'b1;
            end
        join
        drain_wait_a();
        chk("count_8", 64'(word_count_a), 64'd8);
        step();

        // illegal op consumed without a write
        send(0, 4'd12, 5'd1, 5'd1, 5'd1, 16'd1, 26'd0, 32'd0);
        @(negedge clk);
        chk("bad_op", 64'(bad_op_a), 64'd1);
        chk("bad_count", 64'(word_count_a), 64'd8);
        chk("bad_no_we", 64'(mem_we_a), 64'd0);
        step();
        send(0, 4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 26'd0, 32'h14640010);
        send(0, 4'd10, 5'd29, 5'd2, 5'd0, 16'h0008, 26'd0, 32'h8FA20008);
        drain_wait_a();
        chk("count_10", 64'(word_count_a), 64'd10);
        step();

        // finish with two words stuck in the buffer
        mem_ready_a = 1'b0;
        send(0, 4'd3, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0, 32'h24011234);
        send(0, 4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 32'h00210820);
        finish_a = 1'b1;
        step();
        finish_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("drain_busy", {busy_a, done_a}, 64'b10);
        end
        step();
        mem_ready_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("done_busy", 64'(busy_a), 64'd0);
        chk("done_timing", 64'($time - last_wr_a), 64'd10);
        chk("done_queue", 64'(qa.size()), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(done_a), 64'd0);
        step();

        // reset mid-session with a full buffer
        base_a = 10'h100;
        exp_ptr_a = 'h100;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        mem_ready_a = 1'b0;
        send(0, 4'd2, 5'd1, 5'd1, 5'd0, 16'h1, 26'd0, 32'h20210001);
        send(0, 4'd2, 5'd1, 5'd1, 5'd0, 16'h2, 26'd0, 32'h20210002);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 64'(mem_we_a), 64'd0);
        chk("mid_rst_outs",
            {in_ready_a, busy_a, done_a, bad_op_a, word_count_a,
             mem_addr_a, mem_data_a}, 64'd0);
        qa.delete();
        step();
        step();
        reset = 1'b0;
        mem_ready_a = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_we", 64'(mem_we_a), 64'd0);
        end
        step();

        // narrow instance: wrap and capacity
        mem_ready_b = 1'b1;
        base_b = 4'd14;
        exp_ptr_b = 14;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++)
            send(1, 4'd2, 5'd0, 5'd0, 5'd0, 16'(i), 26'd0, 32'h20000000 | i);
        valid_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("cap_ready", 64'(in_ready_b), 64'd0);
        end
        chk("cap_count", 64'(word_count_b), 64'd16);
        step();
        valid_b = 1'b0;
        finish_b = 1'b1;
        step();
        finish_b = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_b) seen = 1;
        end
        chk("b_done_seen", 64'(seen), 64'd1);
        chk("b_queue", 64'(qb.size()), 64'd0);
        chk("a_queue", 64'(qa.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
